// File: rtl/ddr3_arb_pkg.sv
// rtl/ddr3_arb_pkg.sv - shared types and width helper for the DDR3 read/write arbiter
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD
    } state_e;

    typedef enum logic {
        GNT_WR,
        GNT_RD
    } grant_e;

    // Bits needed to hold any value in 0..max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ddr3_rw_arbiter_if.sv
// rtl/ddr3_rw_arbiter_if.sv - client and DDR3 user-port signal bundle for the arbiter
interface ddr3_rw_arbiter_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 22
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  wr_req_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic [BE_WIDTH-1:0]   wr_be_i;
    logic                  wr_ack_o;

    logic                  rd_req_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  rd_ack_o;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;

    logic [ADDR_WIDTH-1:0] ddr3_addr_o;
    logic                  ddr3_write_o;
    logic                  ddr3_read_o;
    logic [BE_WIDTH-1:0]   ddr3_byte_enable_o;
    logic [DATA_WIDTH-1:0] ddr3_write_data_o;
    logic                  ddr3_waitrequest_in;
    logic [DATA_WIDTH-1:0] ddr3_rddata_in;
    logic                  ddr3_rddata_valid_in;
    logic                  rd_underflow_o;

    modport slave (
        input  wr_req_i, wr_addr_i, wr_data_i, wr_be_i,
        input  rd_req_i, rd_addr_i,
        input  ddr3_waitrequest_in, ddr3_rddata_in, ddr3_rddata_valid_in,
        output wr_ack_o, rd_ack_o, rd_data_o, rd_valid_o,
        output ddr3_addr_o, ddr3_write_o, ddr3_read_o, ddr3_byte_enable_o, ddr3_write_data_o,
        output rd_underflow_o
    );

    modport master (
        output wr_req_i, wr_addr_i, wr_data_i, wr_be_i,
        output rd_req_i, rd_addr_i,
        output ddr3_waitrequest_in, ddr3_rddata_in, ddr3_rddata_valid_in,
        input  wr_ack_o, rd_ack_o, rd_data_o, rd_valid_o,
        input  ddr3_addr_o, ddr3_write_o, ddr3_read_o, ddr3_byte_enable_o, ddr3_write_data_o,
        input  rd_underflow_o
    );

endinterface

// File: rtl/ddr3_rr_arb2.sv
// rtl/ddr3_rr_arb2.sv - two-way round-robin pick between writer and reader
module ddr3_rr_arb2
    import ddr3_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_wr,
    input  logic   req_rd,
    input  logic   upd_en,
    input  grant_e upd_gnt,
    output logic   gnt_valid,
    output grant_e gnt
);

    grant_e last_grant_q, last_grant_d;

    // Pick the eligible client; on a tie the one not granted last wins
    always_comb begin
        gnt_valid    = req_wr | req_rd;
        gnt          = GNT_WR;
        last_grant_d = upd_en ? upd_gnt : last_grant_q;
        if (req_wr && req_rd) begin
            gnt = (last_grant_q == GNT_WR) ? GNT_RD : GNT_WR;
        end else if (req_rd) begin
            gnt = GNT_RD;
        end
    end

    // Last grant starts as reader so the writer wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_RD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ddr3_rw_arbiter.sv
// rtl/ddr3_rw_arbiter.sv - shares the DDR3 user command port between frame writer and display reader
module ddr3_rw_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 256,
    parameter int ADDR_WIDTH      = 22,
    parameter int BURST_MAX       = 16,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic             usr_clk,
    input  logic             usr_rst,
    ddr3_rw_arbiter_if.slave bus
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int BEAT_W   = cnt_width(BURST_MAX);
    localparam int OUT_W    = cnt_width(MAX_OUTSTANDING);

    state_e                state_q, state_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [OUT_W-1:0]      rd_out_q, rd_out_d;
    logic                  underflow_q, underflow_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic                  read_q, read_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic              wr_elig, rd_elig, slot_free;
    logic              pick_valid, cur_elig, other_elig;
    logic              load, load_wr, load_rd, rel_en;
    grant_e            pick, cur_gnt;
    state_e            other_state;
    logic [BEAT_W-1:0] beat_inc;

    ddr3_rr_arb2 u_rr (
        .clk       (usr_clk),
        .rst       (usr_rst),
        .req_wr    (wr_elig),
        .req_rd    (rd_elig),
        .upd_en    (rel_en),
        .upd_gnt   (cur_gnt),
        .gnt_valid (pick_valid),
        .gnt       (pick)
    );

    // Eligibility, slot availability and which client owns this cycle's load
    always_comb begin
        wr_elig   = bus.wr_req_i;
        rd_elig   = bus.rd_req_i && (rd_out_q < OUT_W'(MAX_OUTSTANDING));
        slot_free = !(write_q || read_q) || !bus.ddr3_waitrequest_in;
        cur_gnt   = GNT_WR;
        cur_elig  = 1'b0;
        unique case (state_q)
            WR:      begin cur_gnt = GNT_WR; cur_elig = wr_elig;    end
            RD:      begin cur_gnt = GNT_RD; cur_elig = rd_elig;    end
            default: begin cur_gnt = pick;   cur_elig = pick_valid; end
        endcase
        other_elig  = (cur_gnt == GNT_WR) ? rd_elig : wr_elig;
        other_state = (cur_gnt == GNT_WR) ? RD : WR;
        load        = !usr_rst && slot_free && cur_elig;
        load_wr     = load && (cur_gnt == GNT_WR);
        load_rd     = load && (cur_gnt == GNT_RD);
        beat_inc    = beat_cnt_q + BEAT_W'(1);
    end

    // Grant FSM: burst counting and release; IDLE grants and loads in the same cycle
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rel_en     = 1'b0;
        if (state_q != IDLE || pick_valid) begin
            state_d = (cur_gnt == GNT_WR) ? WR : RD;
            if (load) begin
                if (beat_inc == BEAT_W'(BURST_MAX)) begin
                    beat_cnt_d = '0;
                    if (other_elig) begin
                        rel_en  = 1'b1;
                        state_d = other_state;
                    end
                end else begin
                    beat_cnt_d = beat_inc;
                end
            end else if (!cur_elig && slot_free) begin
                rel_en     = 1'b1;
                beat_cnt_d = '0;
                state_d    = other_elig ? other_state : IDLE;
            end
        end
    end

    // Command slot: load from the granted client, else empty once the controller takes it
    always_comb begin
        addr_d  = addr_q;
        write_d = write_q;
        read_d  = read_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        if (load_wr) begin
            addr_d  = bus.wr_addr_i;
            write_d = 1'b1;
            read_d  = 1'b0;
            be_d    = bus.wr_be_i;
            wdata_d = bus.wr_data_i;
        end else if (load_rd) begin
            addr_d  = bus.rd_addr_i;
            write_d = 1'b0;
            read_d  = 1'b1;
            be_d    = '1;
        end else if (slot_free) begin
            write_d = 1'b0;
            read_d  = 1'b0;
        end
    end

    // Outstanding-read tracking with sticky underflow, and one-cycle read return
    always_comb begin
        rd_out_d    = rd_out_q;
        underflow_d = underflow_q;
        if (load_rd && !bus.ddr3_rddata_valid_in) begin
            rd_out_d = rd_out_q + OUT_W'(1);
        end else if (!load_rd && bus.ddr3_rddata_valid_in) begin
            if (rd_out_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                rd_out_d = rd_out_q - OUT_W'(1);
            end
        end
        rd_valid_d = bus.ddr3_rddata_valid_in;
        rd_data_d  = bus.ddr3_rddata_in;
    end

    // All state registers; reset clears the slot even while the controller stalls
    always_ff @(posedge usr_clk) begin
        if (usr_rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            rd_out_q    <= '0;
            underflow_q <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            rd_out_q    <= rd_out_d;
            underflow_q <= underflow_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            read_q      <= read_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign bus.wr_ack_o           = load_wr;
    assign bus.rd_ack_o           = load_rd;
    assign bus.ddr3_addr_o        = addr_q;
    assign bus.ddr3_write_o       = write_q;
    assign bus.ddr3_read_o        = read_q;
    assign bus.ddr3_byte_enable_o = be_q;
    assign bus.ddr3_write_data_o  = wdata_q;
    assign bus.rd_data_o          = rd_data_q;
    assign bus.rd_valid_o         = rd_valid_q;
    assign bus.rd_underflow_o     = underflow_q;

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// tb/tb_ddr3_rw_arbiter.sv - directed self-checking bench for ddr3_rw_arbiter
module tb_ddr3_rw_arbiter;

    localparam int DW = 256;
    localparam int AW = 22;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ddr3_rw_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ddr3_rw_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(16), .MAX_OUTSTANDING(32)
    ) dut (
        .usr_clk (clk),
        .usr_rst (rst),
        .bus     (bus)
    );

    function automatic logic [AW-1:0] wa(input int i);
        return AW'(32'h1000 + i);
    endfunction

    function automatic logic [AW-1:0] ra(input int i);
        return AW'(32'h2000 + i);
    endfunction

    function automatic logic [DW-1:0] wd(input int i);
        return {8{32'hA500_0000 + 32'(i)}};
    endfunction

    function automatic logic [BW-1:0] wb(input int i);
        return BW'(32'hF0F0_0000 | 32'(i));
    endfunction

    task automatic idle_inputs();
        bus.wr_req_i             = 1'b0;
        bus.wr_addr_i            = '0;
        bus.wr_data_i            = '0;
        bus.wr_be_i              = '0;
        bus.rd_req_i             = 1'b0;
        bus.rd_addr_i            = '0;
        bus.ddr3_waitrequest_in  = 1'b0;
        bus.ddr3_rddata_in       = '0;
        bus.ddr3_rddata_valid_in = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        #2;
        checks++;
        if ({bus.ddr3_write_o, bus.ddr3_read_o, bus.wr_ack_o, bus.rd_ack_o, bus.rd_valid_o, bus.rd_underflow_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.ddr3_write_o, bus.ddr3_read_o, bus.wr_ack_o, bus.rd_ack_o, bus.rd_valid_o, bus.rd_underflow_o});
        end
        checks++;
        if (bus.ddr3_addr_o !== '0 || bus.ddr3_byte_enable_o !== '0 || bus.ddr3_write_data_o !== '0 || bus.rd_data_o !== '0) begin
            failures++;
            $display("FAIL reset_data: addr=%h be=%h expected all zero", bus.ddr3_addr_o, bus.ddr3_byte_enable_o);
        end
        bus.wr_req_i = 1'b1;
        #1;
        checks++;
        if (bus.wr_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack: wr_ack_o=%b expected 0", bus.wr_ack_o);
        end
        @(negedge clk);
        bus.wr_req_i = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_writer_only();
        int   n_ack;
        int   cyc;
        logic prev_ack;
        n_ack = 0;
        cyc = 0;
        prev_ack = 1'b0;
        while (n_ack < 40 && cyc < 60) begin
            @(negedge clk);
            bus.wr_req_i  = 1'b1;
            bus.wr_addr_i = wa(n_ack);
            bus.wr_data_i = wd(n_ack);
            bus.wr_be_i   = wb(n_ack);
            #2;
            if (prev_ack) begin
                checks++;
                if (bus.ddr3_write_o !== 1'b1 || bus.ddr3_read_o !== 1'b0 || bus.ddr3_addr_o !== wa(n_ack - 1) ||
                    bus.ddr3_write_data_o !== wd(n_ack - 1) || bus.ddr3_byte_enable_o !== wb(n_ack - 1)) begin
                    failures++;
                    $display("FAIL wr_slot beat %0d: addr=%h write=%b expected addr=%h write=1",
                             n_ack - 1, bus.ddr3_addr_o, bus.ddr3_write_o, wa(n_ack - 1));
                end
            end
            prev_ack = bus.wr_ack_o;
            if (bus.wr_ack_o === 1'b1) n_ack++;
            cyc++;
        end
        checks++;
        if (n_ack !== 40 || cyc !== 40) begin
            failures++;
            $display("FAIL wr_count: acks=%0d cycles=%0d expected 40 acks in 40 cycles", n_ack, cyc);
        end
        @(negedge clk);
        bus.wr_req_i = 1'b0;
        #2;
        checks++;
        if (bus.ddr3_write_o !== 1'b1 || bus.ddr3_addr_o !== wa(39)) begin
            failures++;
            $display("FAIL wr_last: write=%b addr=%h expected 1 %h", bus.ddr3_write_o, bus.ddr3_addr_o, wa(39));
        end
        @(negedge clk);
        #2;
        checks++;
        if (bus.ddr3_write_o !== 1'b0) begin
            failures++;
            $display("FAIL wr_drop: write=%b expected 0", bus.ddr3_write_o);
        end
    endtask

    task automatic test_round_robin();
        int         n_ack;
        int         cyc;
        logic [1:0] exp_ack;
        apply_reset();
        n_ack = 0;
        cyc = 0;
        while (n_ack < 48 && cyc < 70) begin
            @(negedge clk);
            bus.wr_req_i  = 1'b1;
            bus.wr_addr_i = wa(cyc);
            bus.wr_data_i = wd(cyc);
            bus.wr_be_i   = wb(cyc);
            bus.rd_req_i  = 1'b1;
            bus.rd_addr_i = ra(cyc);
            #2;
            if (bus.wr_ack_o === 1'b1 || bus.rd_ack_o === 1'b1) begin
                exp_ack = (((n_ack / 16) % 2) == 0) ? 2'b10 : 2'b01;
                checks++;
                if ({bus.wr_ack_o, bus.rd_ack_o} !== exp_ack) begin
                    failures++;
                    $display("FAIL rr_order cmd %0d: {wr,rd}_ack=%b expected %b", n_ack, {bus.wr_ack_o, bus.rd_ack_o}, exp_ack);
                end
                n_ack++;
            end
            cyc++;
        end
        checks++;
        if (n_ack !== 48 || cyc !== 48) begin
            failures++;
            $display("FAIL rr_count: acks=%0d cycles=%0d expected 48 in 48", n_ack, cyc);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_read_cap();
        int   n_ack;
        logic prev_ack;
        apply_reset();
        n_ack = 0;
        prev_ack = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            bus.rd_req_i  = 1'b1;
            bus.rd_addr_i = ra(n_ack);
            #2;
            if (prev_ack && n_ack == 1) begin
                checks++;
                if (bus.ddr3_read_o !== 1'b1 || bus.ddr3_write_o !== 1'b0 || bus.ddr3_addr_o !== ra(0) ||
                    bus.ddr3_byte_enable_o !== {BW{1'b1}}) begin
                    failures++;
                    $display("FAIL rd_slot: read=%b addr=%h be=%h expected 1 %h all-ones",
                             bus.ddr3_read_o, bus.ddr3_addr_o, bus.ddr3_byte_enable_o, ra(0));
                end
            end
            prev_ack = bus.rd_ack_o;
            if (bus.rd_ack_o === 1'b1) n_ack++;
        end
        checks++;
        if (n_ack !== 32) begin
            failures++;
            $display("FAIL rd_cap: acks=%0d expected 32", n_ack);
        end
        n_ack = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.ddr3_rddata_valid_in = (c == 0);
            bus.ddr3_rddata_in       = {8{32'h5EED_0001}};
            #2;
            if (c == 1) begin
                checks++;
                if (bus.rd_valid_o !== 1'b1 || bus.rd_data_o !== {8{32'h5EED_0001}}) begin
                    failures++;
                    $display("FAIL rd_return: valid=%b data=%h expected 1 5eed0001...", bus.rd_valid_o, bus.rd_data_o[31:0]);
                end
            end
            if (bus.rd_ack_o === 1'b1) n_ack++;
        end
        checks++;
        if (n_ack !== 1) begin
            failures++;
            $display("FAIL rd_refill: acks=%0d expected 1", n_ack);
        end
        checks++;
        if (bus.rd_underflow_o !== 1'b0) begin
            failures++;
            $display("FAIL rd_no_underflow: underflow=%b expected 0", bus.rd_underflow_o);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_waitrequest();
        int   n_ack;
        int   cyc;
        logic prev_ack;
        apply_reset();
        n_ack = 0;
        cyc = 0;
        prev_ack = 1'b0;
        while (n_ack < 10 && cyc < 30) begin
            @(negedge clk);
            bus.ddr3_waitrequest_in = (cyc >= 5 && cyc < 10);
            bus.wr_req_i  = 1'b1;
            bus.wr_addr_i = wa(n_ack);
            bus.wr_data_i = wd(n_ack);
            bus.wr_be_i   = wb(n_ack);
            #2;
            if (prev_ack) begin
                checks++;
                if (bus.ddr3_write_o !== 1'b1 || bus.ddr3_addr_o !== wa(n_ack - 1) || bus.ddr3_write_data_o !== wd(n_ack - 1)) begin
                    failures++;
                    $display("FAIL wait_slot beat %0d: addr=%h write=%b expected %h 1", n_ack - 1, bus.ddr3_addr_o, bus.ddr3_write_o, wa(n_ack - 1));
                end
            end
            if (cyc >= 5 && cyc < 10) begin
                checks++;
                if (bus.wr_ack_o !== 1'b0 || bus.ddr3_write_o !== 1'b1 || bus.ddr3_addr_o !== wa(4) || bus.ddr3_write_data_o !== wd(4)) begin
                    failures++;
                    $display("FAIL wait_hold cyc %0d: ack=%b write=%b addr=%h expected 0 1 %h", cyc, bus.wr_ack_o, bus.ddr3_write_o, bus.ddr3_addr_o, wa(4));
                end
            end
            prev_ack = bus.wr_ack_o;
            if (bus.wr_ack_o === 1'b1) n_ack++;
            cyc++;
        end
        checks++;
        if (n_ack !== 10 || cyc !== 15) begin
            failures++;
            $display("FAIL wait_count: acks=%0d cycles=%0d expected 10 in 15", n_ack, cyc);
        end
        @(negedge clk);
        idle_inputs();
        #2;
        checks++;
        if (bus.ddr3_addr_o !== wa(9) || bus.ddr3_write_o !== 1'b1) begin
            failures++;
            $display("FAIL wait_last: addr=%h write=%b expected %h 1", bus.ddr3_addr_o, bus.ddr3_write_o, wa(9));
        end
    endtask

    task automatic test_same_cycle();
        int n_ack;
        int cyc;
        apply_reset();
        n_ack = 0;
        cyc = 0;
        while (n_ack < 10 && cyc < 20) begin
            @(negedge clk);
            bus.rd_req_i  = 1'b1;
            bus.rd_addr_i = ra(n_ack);
            #2;
            if (bus.rd_ack_o === 1'b1) n_ack++;
            cyc++;
        end
        @(negedge clk);
        bus.rd_addr_i            = ra(10);
        bus.ddr3_rddata_valid_in = 1'b1;
        bus.ddr3_rddata_in       = {8{32'h0000_0A0A}};
        #2;
        checks++;
        if (bus.rd_ack_o !== 1'b1) begin
            failures++;
            $display("FAIL same_ack: rd_ack=%b expected 1", bus.rd_ack_o);
        end
        n_ack = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.ddr3_rddata_valid_in = 1'b0;
            bus.rd_addr_i            = ra(11 + n_ack);
            #2;
            if (bus.rd_ack_o === 1'b1) n_ack++;
        end
        checks++;
        if (n_ack !== 22) begin
            failures++;
            $display("FAIL same_count: further acks=%0d expected 22", n_ack);
        end
        apply_reset();
        @(negedge clk);
        bus.ddr3_rddata_valid_in = 1'b1;
        bus.ddr3_rddata_in       = {8{32'hDEAD_0005}};
        @(negedge clk);
        bus.ddr3_rddata_valid_in = 1'b0;
        #2;
        checks++;
        if (bus.rd_underflow_o !== 1'b1 || bus.rd_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL underflow_set: underflow=%b valid=%b expected 1 1", bus.rd_underflow_o, bus.rd_valid_o);
        end
        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (bus.rd_underflow_o !== 1'b1 || bus.rd_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL underflow_sticky: underflow=%b valid=%b expected 1 0", bus.rd_underflow_o, bus.rd_valid_o);
        end
    endtask

    task automatic test_reset_midcmd();
        int n_ack;
        int cyc;
        apply_reset();
        n_ack = 0;
        cyc = 0;
        while (n_ack < 8 && cyc < 20) begin
            @(negedge clk);
            bus.rd_req_i  = 1'b1;
            bus.rd_addr_i = ra(n_ack);
            #2;
            if (bus.rd_ack_o === 1'b1) n_ack++;
            cyc++;
        end
        @(negedge clk);
        bus.rd_req_i            = 1'b0;
        bus.ddr3_waitrequest_in = 1'b1;
        #2;
        checks++;
        if (bus.ddr3_read_o !== 1'b1 || bus.ddr3_addr_o !== ra(7)) begin
            failures++;
            $display("FAIL midrst_hold: read=%b addr=%h expected 1 %h", bus.ddr3_read_o, bus.ddr3_addr_o, ra(7));
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        checks++;
        if ({bus.ddr3_read_o, bus.ddr3_write_o, bus.rd_ack_o, bus.wr_ack_o, bus.rd_valid_o, bus.rd_underflow_o} !== 6'b0 ||
            bus.ddr3_addr_o !== '0 || bus.ddr3_byte_enable_o !== '0) begin
            failures++;
            $display("FAIL midrst_clear: ctrl=%b addr=%h be=%h expected all zero",
                     {bus.ddr3_read_o, bus.ddr3_write_o, bus.rd_ack_o, bus.wr_ack_o, bus.rd_valid_o, bus.rd_underflow_o},
                     bus.ddr3_addr_o, bus.ddr3_byte_enable_o);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.ddr3_waitrequest_in  = 1'b0;
        bus.ddr3_rddata_valid_in = 1'b1;
        bus.ddr3_rddata_in       = {8{32'hBEEF_0008}};
        @(negedge clk);
        bus.ddr3_rddata_valid_in = 1'b0;
        #2;
        checks++;
        if (bus.rd_valid_o !== 1'b1 || bus.rd_data_o !== {8{32'hBEEF_0008}} || bus.rd_underflow_o !== 1'b1 || bus.ddr3_read_o !== 1'b0) begin
            failures++;
            $display("FAIL midrst_return: valid=%b underflow=%b read=%b expected 1 1 0",
                     bus.rd_valid_o, bus.rd_underflow_o, bus.ddr3_read_o);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_writer_only();
        test_round_robin();
        test_read_cap();
        test_waitrequest();
        test_same_cycle();
        test_reset_midcmd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
